sram_access_ctrl: RTL and testbench



---
 rtl/sram_access_ctrl_pkg.sv | 18 +
 rtl/sram_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_sram_access_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_pkg.sv
// Shared types for the cache data SRAM access path: the sequencer FSM state
// encoding and a helper giving the width of one line slice.
package sram_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    RESP      = 2'd3
  } state_e;

  // Slice width in bits for a line of `width` bits split into 2**log_line_offset slices.
  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned log_line_offset);
    return width >> log_line_offset;
  endfunction

endpackage

// File: rtl/sram_access_ctrl.sv
// Single-outstanding request sequencer in front of the cache data SRAM.
// Accepts one read or write at a time, drives the SRAM pins from registers,
// counts the fixed read latency, and holds the returned line on a response
// channel until the consumer takes it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write             1 = write, 0 = read
//   req_addr/req_offset   line index / slice index (offset used by writes only)
//   req_wdata             full line, only the addressed slice matters to the SRAM
//   resp_valid/resp_ready response handshake, resp_data held until taken
//   sram_read_addr        SRAM read address
//   sram_write_addr/_offset/_data/_enable  SRAM write port
//   sram_read_data        SRAM read data
module sram_access_ctrl
  import sram_access_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned LOG_DEPTH       = 9,
  parameter int unsigned LOG_LINE_OFFSET = 3,
  parameter int unsigned READ_LATENCY    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [LOG_DEPTH-1:0]       req_addr,
  input  logic [LOG_LINE_OFFSET-1:0] req_offset,
  input  logic [WIDTH-1:0]           req_wdata,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [WIDTH-1:0]           resp_data,
  output logic [LOG_DEPTH-1:0]       sram_read_addr,
  output logic [LOG_DEPTH-1:0]       sram_write_addr,
  output logic [LOG_LINE_OFFSET-1:0] sram_write_offset,
  output logic [WIDTH-1:0]           sram_write_data,
  output logic                       sram_write_enable,
  input  logic [WIDTH-1:0]           sram_read_data
);

  localparam int unsigned CntW = $clog2(READ_LATENCY + 1);

  // A zero-latency SRAM cannot be sequenced by this block.
  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("sram_access_ctrl: READ_LATENCY must be at least 1");
  end

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]           resp_data_q, resp_data_d;
  logic [LOG_DEPTH-1:0]       raddr_q, raddr_d;
  logic [LOG_DEPTH-1:0]       waddr_q, waddr_d;
  logic [LOG_LINE_OFFSET-1:0] woff_q, woff_d;
  logic [WIDTH-1:0]           wdata_q, wdata_d;
  logic                       we_q, we_d;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      raddr_q      <= '0;
      waddr_q      <= '0;
      woff_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      raddr_q      <= raddr_d;
      waddr_q      <= waddr_d;
      woff_q       <= woff_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
    end
  end

  // Next-state and next-output decode; everything holds unless a state says otherwise.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    raddr_d      = raddr_q;
    waddr_d      = waddr_q;
    woff_d       = woff_q;
    wdata_d      = wdata_q;
    we_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_write) begin
            state_d = WRITE;
            waddr_d = req_addr;
            woff_d  = req_offset;
            wdata_d = req_wdata;
            we_d    = 1'b1;
          end else begin
            state_d = READ_WAIT;
            raddr_d = req_addr;
            cnt_d   = CntW'(READ_LATENCY);
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      READ_WAIT: begin
        cnt_d = cnt_q - CntW'(1);
        // Last latency cycle: SRAM output is valid at this edge.
        if (cnt_q == CntW'(1)) begin
          resp_data_d  = sram_read_data;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready         = (state_q == IDLE);
  assign resp_valid        = resp_valid_q;
  assign resp_data         = resp_data_q;
  assign sram_read_addr    = raddr_q;
  assign sram_write_addr   = waddr_q;
  assign sram_write_offset = woff_q;
  assign sram_write_data   = wdata_q;
  assign sram_write_enable = we_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: two instances (read latency 1 and 3), each paired
// with a behavioural SRAM, checked against a line-array reference memory.
module tb_sram_access_ctrl;
  import sram_access_ctrl_pkg::*;

  localparam int unsigned W     = 16;
  localparam int unsigned LD    = 9;
  localparam int unsigned LO    = 3;
  localparam int unsigned SW    = slice_width(W, LO);
  localparam int unsigned DEPTH = 1 << LD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic mem_clr;

  logic          a_req_valid, a_req_ready, a_req_write;
  logic [LD-1:0] a_req_addr;
  logic [LO-1:0] a_req_offset;
  logic [W-1:0]  a_req_wdata;
  logic          a_resp_valid, a_resp_ready;
  logic [W-1:0]  a_resp_data;
  logic [LD-1:0] a_raddr, a_waddr;
  logic [LO-1:0] a_woff;
  logic [W-1:0]  a_wdata, a_rdata;
  logic          a_we;

  logic          b_req_valid, b_req_ready, b_req_write;
  logic [LD-1:0] b_req_addr;
  logic [LO-1:0] b_req_offset;
  logic [W-1:0]  b_req_wdata;
  logic          b_resp_valid, b_resp_ready;
  logic [W-1:0]  b_resp_data;
  logic [LD-1:0] b_raddr, b_waddr;
  logic [LO-1:0] b_woff;
  logic [W-1:0]  b_wdata, b_rdata;
  logic          b_we;

  logic [W-1:0] a_mem [DEPTH];
  logic [W-1:0] b_mem [DEPTH];
  logic [W-1:0] b_s1, b_s2;
  logic [W-1:0] ref_mem [DEPTH];

  int total = 0;
  int bad   = 0;

  sram_access_ctrl #(.WIDTH(W), .LOG_DEPTH(LD), .LOG_LINE_OFFSET(LO), .READ_LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_offset(a_req_offset), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_data(a_resp_data),
    .sram_read_addr(a_raddr), .sram_write_addr(a_waddr), .sram_write_offset(a_woff),
    .sram_write_data(a_wdata), .sram_write_enable(a_we), .sram_read_data(a_rdata)
  );

  sram_access_ctrl #(.WIDTH(W), .LOG_DEPTH(LD), .LOG_LINE_OFFSET(LO), .READ_LATENCY(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_offset(b_req_offset), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
    .sram_read_addr(b_raddr), .sram_write_addr(b_waddr), .sram_write_offset(b_woff),
    .sram_write_data(b_wdata), .sram_write_enable(b_we), .sram_read_data(b_rdata)
  );

  // Latency-1 SRAM: slice write on the edge, line readable one edge after the address.
  always_ff @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) a_mem[i] <= '0;
    end else if (a_we) begin
      a_mem[a_waddr][a_woff*SW +: SW] <= a_wdata[a_woff*SW +: SW];
    end
  end
  assign a_rdata = a_mem[a_raddr];

  // Latency-3 SRAM: two extra output pipeline stages, preloaded with a pattern.
  always_ff @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) b_mem[i] <= W'(32'(i) * 32'h1357);
    end else if (b_we) begin
      b_mem[b_waddr][b_woff*SW +: SW] <= b_wdata[b_woff*SW +: SW];
    end
    b_s1 <= b_mem[b_raddr];
    b_s2 <= b_s1;
  end
  assign b_rdata = b_s2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request on instance a, starting and ending on a negedge with req_ready expected high.
  // `stall` cycles of resp_ready low are applied once the response appears.
  task automatic issue(input logic wr, input logic [LD-1:0] ad, input logic [LO-1:0] of,
                       input logic [W-1:0] wd, input int stall);
    int n;
    a_req_valid  = 1'b1;
    a_req_write  = wr;
    a_req_addr   = ad;
    a_req_offset = of;
    a_req_wdata  = wd;
    n = 0;
    while (a_req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
    check("ready_busy", 32'(a_req_ready), 32'd0);
    if (wr) begin
      check("we_pulse", 32'(a_we), 32'd1);
      check("waddr", 32'(a_waddr), 32'(ad));
      check("woffset", 32'(a_woff), 32'(of));
      check("wdata", 32'(a_wdata), 32'(wd));
      ref_mem[ad][of*SW +: SW] = wd[of*SW +: SW];
      @(negedge clk);
      check("we_single", 32'(a_we), 32'd0);
    end else begin
      check("raddr", 32'(a_raddr), 32'(ad));
      n = 0;
      while (a_resp_valid !== 1'b1 && n < 20) begin
        check("we_in_read", 32'(a_we), 32'd0);
        check("ready_in_read", 32'(a_req_ready), 32'd0);
        @(negedge clk);
        n++;
      end
      check("read_latency", 32'(n), 32'd1);
      check("resp_data", 32'(a_resp_data), 32'(ref_mem[ad]));
      check("we_in_resp", 32'(a_we), 32'd0);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check("bp_valid", 32'(a_resp_valid), 32'd1);
        check("bp_data", 32'(a_resp_data), 32'(ref_mem[ad]));
        check("bp_no_accept", 32'(a_req_ready), 32'd0);
      end
      a_resp_ready = 1'b1;
      @(negedge clk);
      check("resp_taken", 32'(a_resp_valid), 32'd0);
    end
    check("ready_back", 32'(a_req_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [LD-1:0] ad;
    logic [LO-1:0] of;
    logic [W-1:0]  wd;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    rst_n = 1'b0;
    mem_clr = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_offset = '0;
    a_req_wdata = '0; a_resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_offset = '0;
    b_req_wdata = '0; b_resp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(a_req_ready), 32'd1);
    check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    check("rst_resp_data", 32'(a_resp_data), 32'd0);
    check("rst_we", 32'(a_we), 32'd0);
    check("rst_raddr", 32'(a_raddr), 32'd0);
    check("rst_waddr", 32'(a_waddr), 32'd0);
    check("rst_woff", 32'(a_woff), 32'd0);
    check("rst_wdata", 32'(a_wdata), 32'd0);
    rst_n = 1'b1;
    mem_clr = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(a_req_ready), 32'd1);

    // Write then read, directed
    issue(1'b1, 9'd5, 3'd2, 16'h0A00, 0);
    a_req_valid = 1'b0;
    issue(1'b0, 9'd5, 3'd0, 16'h0000, 0);
    a_req_valid = 1'b0;
    issue(1'b1, 9'd5, 3'd2, 16'h0A20, 0);
    issue(1'b0, 9'd5, 3'd6, 16'hFFFF, 0);
    a_req_valid = 1'b0;
    check("slice_5_4", 32'(a_resp_data[5:4]), 32'd2);

    // Latency sweep on the latency-3 instance
    b_req_addr = 9'd7;
    b_req_write = 1'b0;
    b_req_valid = 1'b1;
    check("b_ready_idle", 32'(b_req_ready), 32'd1);
    @(negedge clk);
    b_req_valid = 1'b0;
    n = 0;
    while (b_resp_valid !== 1'b1 && n < 20) begin
      check("b_ready_wait", 32'(b_req_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    check("b_latency", 32'(n), 32'd3);
    check("b_resp_data", 32'(b_resp_data), 32'(W'(32'd7 * 32'h1357)));
    check("b_ready_resp", 32'(b_req_ready), 32'd0);
    @(negedge clk);
    check("b_resp_taken", 32'(b_resp_valid), 32'd0);
    check("b_ready_back", 32'(b_req_ready), 32'd1);

    // Response backpressure with a request waiting
    a_resp_ready = 1'b0;
    issue(1'b0, 9'd5, 3'd0, 16'h0000, 10);
    a_req_valid = 1'b0;

    // Reset during READ_WAIT drops the read
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 9'd5;
    @(negedge clk);
    a_req_valid = 1'b0;
    check("mid_read_busy", 32'(a_req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(a_resp_valid), 32'd0);
    check("mid_rst_ready", 32'(a_req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("dropped_read", 32'(a_resp_valid), 32'd0);
    end

    // Reset during WRITE clears the enable immediately, so nothing commits
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 9'd0; a_req_offset = 3'd0;
    a_req_wdata = 16'h0003;
    @(negedge clk);
    a_req_valid = 1'b0;
    check("abort_we_high", 32'(a_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_we_clear", 32'(a_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 9'd0, 3'd0, 16'h0000, 0);
    a_req_valid = 1'b0;

    // Back-to-back alternating writes and reads with req_valid held high
    for (int k = 0; k < 4; k++) begin
      ad = LD'($urandom_range(0, DEPTH - 1));
      of = LO'($urandom);
      wd = W'($urandom);
      issue(1'b1, ad, of, wd, 0);
      issue(1'b0, ad, LO'($urandom), W'($urandom), 0);
    end

    // Random mix over a small address window to hit line reuse
    for (int k = 0; k < 24; k++) begin
      issue(1'($urandom), LD'($urandom_range(0, 7)), LO'($urandom), W'($urandom), 0);
    end
    a_req_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
